// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide data memory with combinational read and synchronous write.
// Handles sub-word read-modify-write, load extension, and alignment/range/funct3 fault checks.
module load_store_unit #(
  parameter int MEM_DEPTH = 10001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  // state  | meaning
  // S_IDLE | ready for a request; faults are detected here
  // S_RD   | mem_a = word index; mem_rd captured at the end of the cycle
  // S_WR   | mem_we high for this single cycle
  // S_RESP | rsp_valid strobe; no request accepted
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [31:0] MemDepthW = 32'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_q, mem_we_d;

  logic        funct3_illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_fault;
  logic [31:0] req_index;
  logic [31:0] held_index;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {24'b0, sh[7:0]};
      3'b101:  load_ext = {16'b0, sh[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Only the addressed byte/halfword lane of the old word is replaced.
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] ins;
    shamt = {off, 3'b000};
    if (f3[0]) begin
      mask = 32'h0000_FFFF << shamt;
      ins  = {16'b0, wd[15:0]} << shamt;
    end else begin
      mask = 32'h0000_00FF << shamt;
      ins  = {24'b0, wd[7:0]} << shamt;
    end
    store_merge = (old & ~mask) | ins;
  endfunction

  assign req_index  = {2'b00, req_addr[31:2]};
  assign held_index = {2'b00, addr_q[31:2]};

  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_illegal = 1'b0;
      3'b100, 3'b101:         funct3_illegal = req_store;
      default:                funct3_illegal = 1'b1;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = req_index >= MemDepthW;
    req_fault    = funct3_illegal || misaligned || out_of_range;
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_fault_d = 1'b0;
    mem_a_d     = 32'h0;
    mem_wd_d    = 32'h0;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_fault) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (!req_store || (req_funct3[1:0] != 2'b10)) begin
            state_d = S_RD;
            mem_a_d = req_index;
          end else begin
            state_d  = S_WR;
            mem_a_d  = req_index;
            mem_we_d = 1'b1;
            mem_wd_d = req_wdata;
          end
        end
      end
      S_RD: begin
        if (store_q) begin
          state_d  = S_WR;
          mem_a_d  = held_index;
          mem_we_d = 1'b1;
          mem_wd_d = store_merge(funct3_q, addr_q[1:0], mem_rd, wdata_q);
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_ext(funct3_q, addr_q[1:0], mem_rd);
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
      mem_a_q     <= 32'h0;
      mem_wd_q    <= 32'h0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Gated by rst so ready is low during reset and rises as soon as reset releases.
  assign req_ready = (state_q == S_IDLE) && rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;
  assign mem_we    = mem_we_q;

endmodule
